// File: rtl/ds_box_scaler.sv
// ds_box_scaler: exact N x N box-average downscaler for a raster pixel stream.
// Optional build macro DS_BOX_ROUND_EN: round half up before the final shift
// (default: plain truncation).
module ds_box_scaler #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 256,
  parameter int unsigned SHIFT = 3,
  localparam int unsigned OUT_W = IMG_W >> SHIFT,
  localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          sof,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [XW-1:0] dout_x
);

  localparam int unsigned N  = 1 << SHIFT;
  localparam int unsigned AW = DW + 2 * SHIFT;
  localparam int unsigned HW = DW + SHIFT;
  localparam int unsigned PW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
`ifdef DS_BOX_ROUND_EN
  localparam logic [AW-1:0] ROUND = AW'(1) << (2 * SHIFT - 1);
`else
  localparam logic [AW-1:0] ROUND = '0;
`endif

  logic [PW-1:0]    r_px;
  logic [SHIFT-1:0] r_ry;
  logic [HW-1:0]    r_hacc;
  logic [AW-1:0]    r_lbuf [OUT_W];

  logic [PW-1:0]    w_px_eff;
  logic [SHIFT-1:0] w_ry_eff;
  logic [SHIFT-1:0] w_sub;
  logic [XW-1:0]    w_ox;
  logic             w_grp_start;
  logic             w_grp_end;
  logic             w_px_last;
  logic             w_ry_first;
  logic             w_ry_last;
  logic [HW-1:0]    w_sum;
  logic [AW-1:0]    w_acc;
  logic [AW-1:0]    w_total;

  // Position of the current pixel (sof forces block origin) and datapath sums
  always_comb begin
    w_px_eff    = sof ? '0 : r_px;
    w_ry_eff    = sof ? '0 : r_ry;
    w_sub       = w_px_eff[SHIFT-1:0];
    w_ox        = XW'(w_px_eff >> SHIFT);
    w_grp_start = (w_sub == '0);
    w_grp_end   = (w_sub == SHIFT'(N - 1));
    w_px_last   = (w_px_eff == PW'(IMG_W - 1));
    w_ry_first  = (w_ry_eff == '0);
    w_ry_last   = (w_ry_eff == SHIFT'(N - 1));
    w_sum       = r_hacc + HW'(din);
    w_acc       = r_lbuf[w_ox] + AW'(w_sum);
    w_total     = w_acc + ROUND;
  end

  // Column/row counters and horizontal group accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px   <= '0;
      r_ry   <= '0;
      r_hacc <= '0;
    end else if (din_valid) begin
      r_hacc <= w_grp_start ? HW'(din) : w_sum;
      if (w_px_last) begin
        r_px <= '0;
        r_ry <= w_ry_last ? '0 : w_ry_eff + SHIFT'(1);
      end else begin
        r_px <= w_px_eff + PW'(1);
        r_ry <= w_ry_eff;
      end
    end
  end

  // Line buffer of partial block sums; the last block row reads only
  always_ff @(posedge clk) begin
    if (din_valid && w_grp_end && !w_ry_last) begin
      r_lbuf[w_ox] <= w_ry_first ? AW'(w_sum) : w_acc;
    end
  end

  // Output register: one-cycle strobe at each completed block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_x     <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (din_valid && w_grp_end && w_ry_last) begin
        dout       <= DW'(w_total >> (2 * SHIFT));
        dout_x     <= w_ox;
        dout_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ds_box_scaler.sv
// Directed bench for ds_box_scaler (DW=8, IMG_W=256, SHIFT=3).
module tb_ds_box_scaler;

  localparam int unsigned DW    = 8;
  localparam int unsigned IMG_W = 256;
  localparam int unsigned SHIFT = 3;
  localparam int unsigned OUT_W = IMG_W >> SHIFT;
  localparam int unsigned XW    = 5;
`ifdef DS_BOX_ROUND_EN
  localparam int RAMP_OFS = 4;
`else
  localparam int RAMP_OFS = 3;
`endif

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          sof;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [XW-1:0] dout_x;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] q_val [$];
  logic [XW-1:0] q_x   [$];

  ds_box_scaler #(.DW(DW), .IMG_W(IMG_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout), .dout_valid(dout_valid), .dout_x(dout_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every strobe half a cycle after it is launched
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      q_val.push_back(dout);
      q_x.push_back(dout_x);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [DW-1:0] d, input logic s);
    din = d; din_valid = 1'b1; sof = s;
    @(posedge clk); #1;
    din_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ramp=1: din = x, else din = val; sof only on the first pixel if first_sof
  task automatic line(input bit ramp, input int val, input bit first_sof);
    for (int x = 0; x < IMG_W; x++)
      pix(ramp ? 8'(x) : 8'(val), (first_sof && x == 0));
  endtask

  // val < 0 means horizontal-ramp expectation
  task automatic chk_strobes(input string tag, input int n, input int val);
    int m;
    chk({tag, "_count"}, q_val.size(), n);
    m = (q_val.size() < n) ? q_val.size() : n;
    for (int i = 0; i < m; i++) begin
      chk({tag, "_dout"}, q_val[i], (val < 0) ? 8 * (i % OUT_W) + RAMP_OFS : val);
      chk({tag, "_x"}, q_x[i], i % OUT_W);
    end
    q_val.delete();
    q_x.delete();
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_valid = 1'b0; sof = 1'b0;
    idle(2);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_x", dout_x, 0);
    rst_n = 1'b1;
    idle(1);

    // Constant frame with strobe latency check on block (0,0)
    line(1'b0, 100, 1'b1);
    for (int y = 1; y < 7; y++) line(1'b0, 100, 1'b0);
    for (int x = 0; x < 7; x++) pix(8'd100, 1'b0);
    chk("lat_pre_valid", dout_valid, 0);
    pix(8'd100, 1'b0);
    chk("lat_valid", dout_valid, 1);
    chk("lat_dout", dout, 100);
    chk("lat_x", dout_x, 0);
    idle(1);
    chk("lat_one_cycle", dout_valid, 0);
    for (int x = 8; x < IMG_W; x++) pix(8'd100, 1'b0);
    for (int y = 8; y < 16; y++) line(1'b0, 100, 1'b0);
    idle(2);
    chk_strobes("const", 64, 100);

    // Horizontal ramp
    line(1'b1, 0, 1'b1);
    for (int y = 1; y < 8; y++) line(1'b1, 0, 1'b0);
    idle(2);
    chk_strobes("ramp", 32, -1);

    // Maximum value
    line(1'b0, 255, 1'b1);
    for (int y = 1; y < 8; y++) line(1'b0, 255, 1'b0);
    idle(2);
    chk_strobes("max", 32, 255);

    // Throttled ramp: gap after every pixel plus random stalls; idle sof is noise
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        pix(8'(x), (y == 0 && x == 0));
        din = 8'($urandom);
        sof = 1'($urandom);
        idle(1 + int'($urandom_range(0, 5)));
        sof = 1'b0;
      end
    end
    idle(2);
    chk_strobes("thr", 32, -1);

    // Resync: 7 lines + 7 pixels of 200, then sof lands on a would-be group end
    line(1'b0, 200, 1'b1);
    for (int y = 1; y < 7; y++) line(1'b0, 200, 1'b0);
    for (int x = 0; x < 7; x++) pix(8'd200, 1'b0);
    idle(1);
    chk("resync_pre_count", q_val.size(), 0);
    pix(8'd10, 1'b1);
    chk("resync_sof_no_strobe", dout_valid, 0);
    for (int x = 1; x < IMG_W; x++) pix(8'd10, 1'b0);
    for (int y = 1; y < 8; y++) line(1'b0, 10, 1'b0);
    idle(2);
    chk("resync_hold_dout", dout, 10);
    chk_strobes("resync", 32, 10);

    // Reset mid-frame: asynchronous clear, then fresh frame without sof
    line(1'b0, 77, 1'b1);
    for (int y = 1; y < 5; y++) line(1'b0, 77, 1'b0);
    for (int x = 0; x < 100; x++) pix(8'd77, 1'b0);
    q_val.delete();
    q_x.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_valid", dout_valid, 0);
    chk("arst_x", dout_x, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int y = 0; y < 8; y++) line(1'b0, 50, 1'b0);
    idle(2);
    chk_strobes("post_rst", 32, 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
